// File: rtl/dpe_acc_tree.sv
// Pipelined vector-sum and group accumulator: a registered binary adder tree feeds
// an ACC_W-bit group accumulator that emits one result per in_last-tagged group.
module dpe_acc_tree #(
  parameter int N_IN  = 8,
  parameter int IN_W  = 8,
  parameter int ACC_W = 24,
  parameter bit SAT   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_IN-1:0][IN_W-1:0]      in_data,
  input  logic                           c_in,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_sum,
  output logic                           out_ovf
);

  localparam int L   = $clog2(N_IN);
  localparam int NP  = 1 << L;
  localparam int TW  = IN_W + L + 1;
  localparam int AW1 = ACC_W + 1;

  if (N_IN < 2) begin : g_bad_n_in
    $error("dpe_acc_tree: N_IN must be at least 2");
  end
  if (ACC_W < TW) begin : g_bad_acc_w
    $error("dpe_acc_tree: ACC_W must be at least IN_W + clog2(N_IN) + 1");
  end

  // A stalled result at the output freezes every stage, so nothing is lost or duplicated.
  logic adv;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  // Node storage is full tree width at every level; sums cannot exceed it.
  logic [TW-1:0] node_reg [0:L][0:NP-1];
  logic [L:0]    valid_reg;
  logic [L:0]    last_reg;
  logic          carry_reg;

  genvar gi, gk;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_stage0
      if (gi < N_IN) begin : g_op
        always_ff @(posedge clk) begin
          if (adv) node_reg[0][gi] <= TW'(in_data[gi]);
        end
      end else begin : g_pad
        always_ff @(posedge clk) begin
          if (adv) node_reg[0][gi] <= '0;
        end
      end
    end

    for (gk = 1; gk <= L; gk++) begin : g_level
      for (gi = 0; gi < NP; gi++) begin : g_node
        if (gi < (NP >> gk)) begin : g_add
          always_ff @(posedge clk) begin
            if (adv)
              node_reg[gk][gi] <= node_reg[gk-1][2*gi] + node_reg[gk-1][2*gi+1]
                                  + ((gk == 1 && gi == 0) ? TW'(carry_reg) : TW'(0));
          end
        end else begin : g_idle
          always_ff @(posedge clk) begin
            if (adv) node_reg[gk][gi] <= '0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (adv) begin
      valid_reg <= {valid_reg[L-1:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      last_reg  <= {last_reg[L-1:0], in_last};
      carry_reg <= c_in;
    end
  end

  // Accumulator stage
  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic             first_reg;
  logic             fin_valid_reg;
  logic [ACC_W-1:0] fin_sum_reg;
  logic             fin_ovf_reg;

  logic [ACC_W-1:0] acc_base;
  logic [AW1-1:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  always_comb begin
    acc_base = first_reg ? '0 : acc_reg;
    sum_ext  = {1'b0, acc_base} + AW1'(node_reg[L][0]);
    ovf_next = (~first_reg & ovf_reg) | sum_ext[ACC_W];
    // Once clamped, the flag stays set, so the group stays pinned at full scale.
    if (SAT && ovf_next) acc_next = '1;
    else                 acc_next = sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      first_reg     <= 1'b1;
      fin_valid_reg <= 1'b0;
      fin_sum_reg   <= '0;
      fin_ovf_reg   <= 1'b0;
    end else if (adv) begin
      fin_valid_reg <= valid_reg[L] & last_reg[L];
      if (valid_reg[L]) begin
        if (last_reg[L]) begin
          fin_sum_reg <= acc_next;
          fin_ovf_reg <= ovf_next;
          acc_reg     <= '0;
          ovf_reg     <= 1'b0;
          first_reg   <= 1'b1;
        end else begin
          acc_reg     <= acc_next;
          ovf_reg     <= ovf_next;
          first_reg   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_valid_reg;
      if (fin_valid_reg) begin
        out_sum <= fin_sum_reg;
        out_ovf <= fin_ovf_reg;
      end
    end
  end

endmodule
